// File: rtl/ol_link_trainer_if.sv
// ol_link_trainer_if: transmit/receive word bus between the link trainer and the frame builder / PCS.
interface ol_link_trainer_if #(
    parameter int DW = 16
);
    logic [DW-1:0]   data_tx;
    logic [DW-1:0]   data_rx;
    logic            ena_rx;
    logic [DW-1:0]   data_out;
    logic [DW/8-1:0] datak;
    logic            ena_tx;
    modport master (input data_tx, data_rx, ena_rx, output data_out, datak, ena_tx);
    modport slave (output data_tx, data_rx, ena_rx, input data_out, datak, ena_tx);
endinterface

// File: rtl/ol_link_trainer.sv
// ol_link_trainer: optical-link bring-up: alignment, counter link test with lock, monitored data pass-through.
module ol_link_trainer #(
    parameter int          DW             = 16,
    parameter logic [DW-1:0] ALIGN_WORD   = 16'h50BC,
    parameter int unsigned ALIGN_CYCLES   = 32'h000F_EEEF,
    parameter int unsigned ALIGN_K_CYCLES = 32'h000F_DDDD,
    parameter int unsigned TEST_CYCLES    = 4096,
    parameter int unsigned LOCK_RUN       = 2047,
    parameter int unsigned LOSS_CYCLES    = 16,
    parameter int unsigned MAX_RETRY      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LIVE,
    ol_link_trainer_if.master lnk,
    output logic [1:0]        mode,
    output logic              link_up,
    output logic              send_err,
    output logic              error,
    output logic [7:0]        retry_cnt,
    output logic [15:0]       err_cnt
);
    typedef enum logic [1:0] {S_ALIGN = 2'b00, S_TEST = 2'b01, S_DATA = 2'b10, S_FAIL = 2'b11} state_t;
    state_t        state;
    logic [31:0]   timer, run, loss, run_nxt, loss_nxt;
    logic [DW-1:0] tx_cnt, prev;
    logic          lock, good, test_end, loss_ev, fail_nxt;
    logic [7:0]    retry_inc;
    // a good word continues the counter sequence; modular subtraction makes the wrap to zero good
    always_comb begin
        good      = lnk.ena_rx && (lnk.data_rx - prev == DW'(1));
        run_nxt   = !good ? '0 : run == LOCK_RUN ? run : run + 1;
        loss_nxt  = lnk.ena_rx ? '0 : loss + 1;
        test_end  = state == S_TEST && timer == TEST_CYCLES - 1;
        loss_ev   = state == S_DATA && loss_nxt == LOSS_CYCLES;
        retry_inc = &retry_cnt ? retry_cnt : retry_cnt + 1'b1;
        fail_nxt  = retry_inc == 8'(MAX_RETRY);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_ALIGN;
            timer        <= '0;
            tx_cnt       <= '0;
            prev         <= '0;
            run          <= '0;
            lock         <= 1'b0;
            loss         <= '0;
            mode         <= 2'b00;
            lnk.data_out <= '0;
            lnk.datak    <= '0;
            lnk.ena_tx   <= 1'b0;
            link_up      <= 1'b0;
            send_err     <= 1'b0;
            error        <= 1'b1;
            retry_cnt    <= '0;
            err_cnt      <= '0;
        end else begin
            prev         <= lnk.data_rx;
            mode         <= state;
            lnk.data_out <= state == S_TEST ? tx_cnt : state == S_DATA ? lnk.data_tx : ALIGN_WORD;
            lnk.datak    <= (state == S_FAIL || (state == S_ALIGN && timer < ALIGN_K_CYCLES)) ? '1 : '0;
            lnk.ena_tx   <= state == S_TEST || state == S_DATA || (state == S_ALIGN && timer >= ALIGN_K_CYCLES);
            link_up      <= LIVE && state == S_DATA && !loss_ev;
            send_err     <= 1'b0;
            // LIVE low overrides any test-end or loss event in the same cycle
            if (!LIVE) begin
                state     <= S_ALIGN;
                timer     <= '0;
                retry_cnt <= '0;
                loss      <= '0;
            end else begin
                case (state)
                    S_ALIGN: begin
                        timer <= timer + 1;
                        if (timer == ALIGN_CYCLES - 1) begin
                            state  <= S_TEST;
                            timer  <= '0;
                            tx_cnt <= '0;
                            run    <= '0;
                            lock   <= 1'b0;
                        end
                    end
                    S_TEST: begin
                        timer  <= timer + 1;
                        tx_cnt <= tx_cnt + 1'b1;
                        run    <= run_nxt;
                        lock   <= lock || run_nxt == LOCK_RUN;
                        if (test_end) begin
                            send_err <= 1'b1;
                            error    <= !lock;
                            timer    <= '0;
                            if (lock) state <= S_DATA;
                            else begin
                                retry_cnt <= retry_inc;
                                state     <= fail_nxt ? S_FAIL : S_ALIGN;
                            end
                        end
                    end
                    S_DATA: begin
                        loss    <= loss_nxt;
                        err_cnt <= (lnk.ena_rx || &err_cnt) ? err_cnt : err_cnt + 1'b1;
                        if (loss_ev) begin
                            loss      <= '0;
                            timer     <= '0;
                            retry_cnt <= retry_inc;
                            state     <= fail_nxt ? S_FAIL : S_ALIGN;
                        end
                    end
                    S_FAIL: error <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ol_link_trainer.sv
// tb_ol_link_trainer: directed bench for the link trainer with small alignment/test lengths.
module tb_ol_link_trainer;
    logic        clk = 1'b0, rst = 1'b1, live = 1'b1;
    logic [1:0]  mode;
    logic        link_up, send_err, error;
    logic [7:0]  retry_cnt;
    logic [15:0] err_cnt;
    logic        lb = 1'b1, flip_en = 1'b0, rx_ena = 1'b1;
    logic [15:0] rx_drv = '0, tx_val = '0;
    int          cyc = 0, n_chk = 0, n_err = 0;
    ol_link_trainer_if #(.DW(16)) ifc ();
    ol_link_trainer #(
        .DW(16), .ALIGN_WORD(16'h50BC), .ALIGN_CYCLES(64), .ALIGN_K_CYCLES(48),
        .TEST_CYCLES(256), .LOCK_RUN(100), .LOSS_CYCLES(16), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .LIVE(live), .lnk(ifc), .mode(mode), .link_up(link_up),
        .send_err(send_err), .error(error), .retry_cnt(retry_cnt), .err_cnt(err_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // loopback, with an optional single-bit corruption every 50 cycles
    assign ifc.data_rx = lb ? (ifc.data_out ^ ((flip_en && cyc % 50 == 0) ? 16'h0004 : 16'h0000)) : rx_drv;
    assign ifc.ena_rx  = rx_ena;
    assign ifc.data_tx = tx_val;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_mode(input logic [1:0] m, input string tag);
        int n = 0;
        while (mode !== m && n < 1000) begin
            tick(1);
            n++;
        end
        chk(tag, mode, m);
    endtask
    task automatic wait_se(input string tag);
        int n = 0;
        while (send_err !== 1'b1 && n < 600) begin
            tick(1);
            n++;
        end
        chk(tag, send_err, 1);
    endtask
    task automatic check_reset(input string t);
        chk({t, "_mode"}, mode, 0);
        chk({t, "_data_out"}, ifc.data_out, 0);
        chk({t, "_datak"}, ifc.datak, 0);
        chk({t, "_ena_tx"}, ifc.ena_tx, 0);
        chk({t, "_link_up"}, link_up, 0);
        chk({t, "_send_err"}, send_err, 0);
        chk({t, "_error"}, error, 1);
        chk({t, "_retry"}, retry_cnt, 0);
        chk({t, "_err_cnt"}, err_cnt, 0);
    endtask
    initial begin
        tick(2);
        check_reset("rst0");
        rst = 1'b0;
        for (int i = 1; i <= 65; i++) begin
            tick(1);
            if (i == 1) begin
                chk("align_word", ifc.data_out, 16'h50BC);
                chk("align_k_first", {ifc.ena_tx, ifc.datak}, 3'b011);
            end
            if (i == 48) chk("align_k_last", {ifc.ena_tx, ifc.datak}, 3'b011);
            if (i == 49) chk("align_d_first", {ifc.ena_tx, ifc.datak}, 3'b100);
            if (i == 64) chk("align_mode_end", mode, 0);
            if (i == 65) begin
                chk("test_mode", mode, 1);
                chk("test_first_word", ifc.data_out, 0);
            end
        end
        tick(1);
        chk("test_count", ifc.data_out, 1);
        tick(254);
        chk("test_end_strobe", send_err, 1);
        chk("test_end_pass", error, 0);
        tick(1);
        chk("strobe_one_cycle", send_err, 0);
        chk("data_mode", mode, 2);
        chk("data_link_up", link_up, 1);
        tx_val = 16'hA5A5;
        tick(1);
        chk("pass_a5a5", ifc.data_out, 16'hA5A5);
        chk("pass_ctl", {ifc.ena_tx, ifc.datak}, 3'b100);
        tx_val = 16'h1234;
        tick(1);
        chk("pass_1234", ifc.data_out, 16'h1234);
        rx_ena = 1'b0;
        tick(15);
        chk("loss15_err_cnt", err_cnt, 15);
        chk("loss15_link_up", link_up, 1);
        chk("loss15_retry", retry_cnt, 0);
        rx_ena = 1'b1;
        tick(1);
        chk("loss15_mode", mode, 2);
        rx_ena = 1'b0;
        tick(16);
        rx_ena = 1'b1;
        chk("loss16_err_cnt", err_cnt, 31);
        chk("loss16_link_down", link_up, 0);
        chk("loss16_retry", retry_cnt, 1);
        tick(1);
        chk("loss16_mode", mode, 0);
        chk("loss16_err_hold", err_cnt, 31);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        flip_en = 1'b1;
        wait_se("flip1_strobe");
        chk("flip1_error", error, 1);
        chk("flip1_retry", retry_cnt, 1);
        tick(1);
        wait_se("flip2_strobe");
        chk("flip2_error", error, 1);
        chk("flip2_retry", retry_cnt, 2);
        tick(3);
        chk("fail_mode", mode, 3);
        chk("fail_ctl", {ifc.ena_tx, ifc.datak}, 3'b011);
        chk("fail_word", ifc.data_out, 16'h50BC);
        chk("fail_link_up", link_up, 0);
        chk("fail_error", error, 1);
        flip_en = 1'b0;
        tick(20);
        chk("fail_sticky", mode, 3);
        live = 1'b0;
        tick(1);
        live = 1'b1;
        chk("live_retry_clr", retry_cnt, 0);
        tick(1);
        chk("live_mode_align", mode, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lb = 1'b0;
        rx_ena = 1'b0;
        rx_drv = '0;
        wait_mode(1, "wrap_enter_test");
        rx_ena = 1'b1;
        rx_drv = 16'hFFB0;
        for (int k = 0; k < 160; k++) begin
            tick(1);
            rx_drv = rx_drv + 1'b1;
        end
        rx_drv = '0;
        wait_se("wrap_strobe");
        chk("wrap_lock", error, 0);
        tick(1);
        chk("wrap_data", mode, 2);
        lb = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        wait_mode(1, "midtest_enter");
        tick(20);
        rst = 1'b1;
        tick(1);
        check_reset("rst_test");
        rst = 1'b0;
        wait_mode(2, "middata_enter");
        rx_ena = 1'b0;
        tick(3);
        rx_ena = 1'b1;
        chk("middata_err_cnt", err_cnt, 3);
        rst = 1'b1;
        tick(1);
        check_reset("rst_data");
        rst = 1'b0;
        wait_mode(1, "livedrop_enter");
        tick(254);
        live = 1'b0;
        tick(1);
        chk("livedrop_no_strobe", send_err, 0);
        chk("livedrop_retry", retry_cnt, 0);
        tick(1);
        live = 1'b1;
        chk("livedrop_mode", mode, 0);
        chk("livedrop_no_strobe2", send_err, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1);
    end
endmodule
